// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in/parallel-out deserializer.
// SIPO_PARITY_EN selects whether a trailing even-parity bit follows each word.
package sipo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam int SIPO_DEFAULT_WIDTH = 4;

`ifdef SIPO_PARITY_EN
  localparam bit PARITY_MODE = 1'b1;
`else
  localparam bit PARITY_MODE = 1'b0;
`endif

endpackage

// File: rtl/sipo_bit_cnt.sv
// Data-bit counter for the deserializer; done flags the bit that completes a word.
module sipo_bit_cnt
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic clear,
  input  logic inc,
  input  logic rst_cnt,
  output logic done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0] cnt_reg;

  // Saturates at WIDTH; it is only brought back to zero on re-entry to IDLE.
  always_ff @(posedge clk) begin
    if (clear || rst_cnt) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != CW'(WIDTH))) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign done = inc && (cnt_reg == CW'(WIDTH - 1));

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-to-parallel front end with valid/ready word output and serial backpressure.
// Optional macro SIPO_PARITY_EN adds a trailing even-parity bit and drives par_err.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH     = SIPO_DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             s_in,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             abort,
  output logic [WIDTH-1:0] p_data,
  output logic             p_valid,
  input  logic             p_ready,
  output logic             par_err
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next, p_data_reg;
  logic             p_valid_reg;
  logic             abort_act, accept, inc, done, load_word, handshake, rst_cnt;

  sipo_bit_cnt #(.WIDTH(WIDTH)) u_bit_cnt (
    .clk     (clk),
    .clear   (clear),
    .inc     (inc),
    .rst_cnt (rst_cnt),
    .done    (done)
  );

  always_ff @(posedge clk) begin
    if (clear) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // abort only bites mid-word, and when it does it also swallows the bit on s_in.
  always_comb begin
    abort_act  = abort && ((state_reg == SHIFT) || (state_reg == PARITY));
    s_ready    = !clear && (state_reg != HOLD);
    accept     = s_valid && s_ready && !abort_act;
    inc        = accept && (state_reg != PARITY);
    handshake  = (state_reg == HOLD) && p_ready;
    load_word  = 1'b0;
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = SHIFT;
      end
      SHIFT: begin
        if (abort_act) begin
          state_next = IDLE;
        end else if (done) begin
          if (PARITY_MODE) begin
            state_next = PARITY;
          end else begin
            state_next = HOLD;
            load_word  = 1'b1;
          end
        end
      end
      PARITY: begin
        if (abort_act) begin
          state_next = IDLE;
        end else if (accept) begin
          state_next = HOLD;
          load_word  = 1'b1;
        end
      end
      HOLD: begin
        if (handshake) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    rst_cnt = abort_act || handshake;
  end

  // Next shift-register image: first bit migrates toward the configured end.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
    if (MSB_FIRST) begin : g_msb
      if (gi == 0) begin : g_in
        assign shift_next[gi] = s_in;
      end else begin : g_mv
        assign shift_next[gi] = shift_reg[gi-1];
      end
    end else begin : g_lsb
      if (gi == WIDTH - 1) begin : g_in
        assign shift_next[gi] = s_in;
      end else begin : g_mv
        assign shift_next[gi] = shift_reg[gi+1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      shift_reg   <= '0;
      p_data_reg  <= '0;
      p_valid_reg <= 1'b0;
    end else begin
      if (abort_act)  shift_reg <= '0;
      else if (inc)   shift_reg <= shift_next;
      if (load_word) begin
        p_valid_reg <= 1'b1;
`ifdef SIPO_PARITY_EN
        p_data_reg  <= shift_reg;
`else
        p_data_reg  <= shift_next;
`endif
      end else if (handshake) begin
        p_valid_reg <= 1'b0;
      end
    end
  end

`ifdef SIPO_PARITY_EN
  logic par_err_reg;

  // Even parity over data plus parity bit: any odd total is an error.
  always_ff @(posedge clk) begin
    if (clear)          par_err_reg <= 1'b0;
    else if (load_word) par_err_reg <= (^shift_reg) ^ s_in;
    else if (handshake) par_err_reg <= 1'b0;
  end

  assign par_err = par_err_reg;
`else
  assign par_err = 1'b0;
`endif

  assign p_data  = p_data_reg;
  assign p_valid = p_valid_reg;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: MSB-first and LSB-first instances share one stimulus
// stream; a scoreboard queue holds the expected word for each instance.
module tb_sipo_deserializer;

  logic       clk = 1'b0;
  logic       clear, s_in, s_valid, abort, p_ready;
  logic       m_s_ready, l_s_ready, m_p_valid, l_p_valid, m_par_err, l_par_err;
  logic [3:0] m_p_data, l_p_data;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] msb;
    logic [3:0] lsb;
    logic       perr;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon, last_e;
  logic m_prev;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .clear(clear), .s_in(s_in), .s_valid(s_valid), .s_ready(m_s_ready),
    .abort(abort), .p_data(m_p_data), .p_valid(m_p_valid), .p_ready(p_ready),
    .par_err(m_par_err)
  );

  sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .clear(clear), .s_in(s_in), .s_valid(s_valid), .s_ready(l_s_ready),
    .abort(abort), .p_data(l_p_data), .p_valid(l_p_valid), .p_ready(p_ready),
    .par_err(l_par_err)
  );

  // Scoreboard: each rising p_valid pops one expected word.
  always @(negedge clk) begin
    if (m_p_valid === 1'b1 && m_prev !== 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL word_unexpected: msb=%b lsb=%b but no word was expected", m_p_data, l_p_data);
      end else begin
        e_mon  = exp_q.pop_front();
        last_e = e_mon;
        if (m_p_data !== e_mon.msb || l_p_data !== e_mon.lsb || l_p_valid !== 1'b1 ||
            m_par_err !== e_mon.perr || l_par_err !== e_mon.perr) begin
          bad++;
          $display("FAIL word: got msb=%b lsb=%b lvalid=%b perr=%b/%b, want msb=%b lsb=%b lvalid=1 perr=%b",
                   m_p_data, l_p_data, l_p_valid, m_par_err, l_par_err, e_mon.msb, e_mon.lsb, e_mon.perr);
        end else begin
          $display("word ok: msb=%b lsb=%b perr=%b", m_p_data, l_p_data, m_par_err);
        end
      end
    end
    m_prev = m_p_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  // Sends one word (w[3] first) plus a parity bit when parity is compiled in.
  task automatic send_word(input logic [3:0] w, input int gap, input logic pbit, input logic abort_first);
    exp_t e;
    logic last;
    e.msb = w;
    for (int k = 0; k < 4; k++) e.lsb[k] = w[3-k];
`ifdef SIPO_PARITY_EN
    e.perr = (^w) ^ pbit;
`else
    e.perr = 1'b0;
`endif
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
`ifdef SIPO_PARITY_EN
      last = (i == 4);
`else
      if (i == 4) break;
      last = (i == 3);
`endif
      if (i > 0 && gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
      s_valid = 1'b1;
      s_in    = (i < 4) ? w[3-i] : pbit;
      abort   = abort_first && (i == 0);
      @(negedge clk);
      total++;
      if (m_s_ready !== 1'b1 || l_s_ready !== 1'b1 || (last && m_p_valid !== 1'b0)) begin
        bad++;
        $display("FAIL bit_ready: bit %0d s_ready=%b/%b p_valid=%b, want ready=1 (p_valid=0 before last)",
                 i, m_s_ready, l_s_ready, m_p_valid);
      end
      if (last) exp_q.push_back(e);
      @(posedge clk); #1;
      s_valid = 1'b0;
      abort   = 1'b0;
    end
    @(negedge clk);
    total++;
    if (m_p_valid !== 1'b1 || m_s_ready !== 1'b0 || l_s_ready !== 1'b0) begin
      bad++;
      $display("FAIL word_latency: p_valid=%b s_ready=%b/%b one cycle after last bit, want p_valid=1 s_ready=0",
               m_p_valid, m_s_ready, l_s_ready);
    end
    $display("sent word %b gap=%0d", w, gap);
  endtask

  task automatic send_partial(input logic b);
    @(posedge clk); #1;
    s_valid = 1'b1;
    s_in    = b;
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic handshake();
    @(posedge clk); #1;
    p_ready = 1'b1;
    @(posedge clk); #1;
    p_ready = 1'b0;
    @(negedge clk);
    total++;
    if (m_p_valid !== 1'b0 || l_p_valid !== 1'b0 || m_s_ready !== 1'b1 ||
        m_par_err !== 1'b0 || l_par_err !== 1'b0 || m_p_data !== last_e.msb || l_p_data !== last_e.lsb) begin
      bad++;
      $display("FAIL handshake: p_valid=%b/%b s_ready=%b perr=%b/%b data=%b/%b, want 0/0 1 0/0 %b/%b",
               m_p_valid, l_p_valid, m_s_ready, m_par_err, l_par_err, m_p_data, l_p_data,
               last_e.msb, last_e.lsb);
    end
    $display("handshake done");
  endtask

  task automatic test_reset();
    clear = 1'b1; s_valid = 1'b1; s_in = 1'b1; abort = 1'b0; p_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if (m_p_data !== 4'b0 || l_p_data !== 4'b0 || m_p_valid !== 1'b0 || l_p_valid !== 1'b0 ||
          m_s_ready !== 1'b0 || l_s_ready !== 1'b0 || m_par_err !== 1'b0) begin
        bad++;
        $display("FAIL reset: data=%b/%b valid=%b/%b ready=%b/%b perr=%b, want all zero",
                 m_p_data, l_p_data, m_p_valid, l_p_valid, m_s_ready, l_s_ready, m_par_err);
      end
    end
    @(posedge clk); #1;
    clear = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    total++;
    if (m_s_ready !== 1'b1 || l_s_ready !== 1'b1 || m_p_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: s_ready=%b/%b p_valid=%b, want 1/1 0", m_s_ready, l_s_ready, m_p_valid);
    end
    $display("reset checked");
  endtask

  task automatic test_back_to_back();
    send_word(4'b1011, 0, 1'b1, 1'b0);
    handshake();
  endtask

  task automatic test_gappy();
    send_word(4'b1100, 3, 1'b0, 1'b0);
    handshake();
  endtask

  task automatic test_backpressure();
    send_word(4'b1011, 0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      s_valid = 1'b1;
      s_in    = i[0];
      @(negedge clk);
      total++;
      if (m_p_data !== 4'b1011 || l_p_data !== 4'b1101 || m_p_valid !== 1'b1 || m_s_ready !== 1'b0) begin
        bad++;
        $display("FAIL backpressure: cycle %0d data=%b/%b valid=%b ready=%b, want 1011/1101 1 0",
                 i, m_p_data, l_p_data, m_p_valid, m_s_ready);
      end
    end
    // Handshake edge with s_valid still high: the bit must not be taken.
    @(posedge clk); #1;
    p_ready = 1'b1; s_valid = 1'b1; s_in = 1'b1;
    @(posedge clk); #1;
    p_ready = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    total++;
    if (m_p_valid !== 1'b0 || m_s_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: p_valid=%b s_ready=%b, want 0 1", m_p_valid, m_s_ready);
    end
    send_word(4'b0111, 0, 1'b1, 1'b0);
    handshake();
  endtask

  task automatic test_abort();
    send_partial(1'b1);
    send_partial(1'b1);
    @(posedge clk); #1;
    abort = 1'b1; s_valid = 1'b1; s_in = 1'b0;
    @(posedge clk); #1;
    abort = 1'b0; s_valid = 1'b0;
    send_word(4'b1001, 0, 1'b0, 1'b0);
    @(posedge clk); #1;
    abort = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    total++;
    if (m_p_valid !== 1'b1 || m_p_data !== 4'b1001 || l_p_data !== 4'b1001) begin
      bad++;
      $display("FAIL abort_hold: p_valid=%b data=%b/%b, want 1 1001/1001", m_p_valid, m_p_data, l_p_data);
    end
    handshake();
    // abort in IDLE is ignored, so the first bit still counts.
    send_word(4'b0101, 0, 1'b0, 1'b1);
    handshake();
  endtask

  task automatic test_parity();
    send_word(4'b1111, 0, 1'b0, 1'b0);
    handshake();
    send_word(4'b0001, 1, 1'b0, 1'b0);
    handshake();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gappy();
    test_backpressure();
    test_abort();
    test_parity();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover: %0d expected words never delivered, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
- Serial-in, parallel-out front end that sits directly upstream of the team's parallel-in/parallel-out register.
- Collects WIDTH serial bits, which may arrive in a gappy stream, into one parallel word.
- Holds each completed word on p_data with a valid/ready handshake until the downstream register takes it.
- Applies backpressure to the serial source while a completed word is waiting.

Parameters:
- WIDTH, 4, parallel word width in bits; must be at least 2.
- MSB_FIRST, 1, bit order: 1 means the first accepted bit lands in p_data[WIDTH-1]; 0 means it lands in p_data[0].

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- clear  input  1  synchronous, active-high reset.
- s_in  input  1  serial data bit.
- s_valid  input  1  s_in is valid this cycle.
- s_ready  output  1  block will accept s_in this cycle; forced to 0 while clear=1.
- abort  input  1  discard any partially assembled word.
- p_data  output  WIDTH  assembled parallel word.
- p_valid  output  1  p_data holds a complete word.
- p_ready  input  1  downstream accepts p_data.
- par_err  output  1  parity error flag for the held word.

Behaviour:
- Interface (already decided): single clock clk; reset is clear, synchronous and active-high.
- Reset: when clear=1 at an edge:
  - state <- IDLE, bit count <- 0, shift register <- 0;
  - p_data=0, p_valid=0, par_err=0;
  - s_ready=0 while clear=1.
  - clear overrides abort, s_valid and p_ready.
- Serial accept: a bit is accepted at an edge where s_valid && s_ready. s_valid=1 with s_ready=0 has no effect.
- States:
  - IDLE: no bits held; s_ready=1.
    - Accepted bit -> SHIFT, count=1.
  - SHIFT: 1 to WIDTH-1 bits held; s_ready=1.
    - Each accepted bit increments count.
    - When the WIDTH-th bit is accepted -> HOLD; or -> PARITY when PARITY_EN is defined.
  - PARITY: only exists when PARITY_EN is defined; s_ready=1.
    - Next accepted bit is the parity bit, not data -> HOLD.
  - HOLD: s_ready=0; p_valid=1.
    - Edge with p_ready=1 -> IDLE; p_valid drops at that edge.
- Word output timing:
  - p_data and p_valid are registered.
  - Both update at the same edge that accepts the final bit, so p_valid is high in the very next cycle.
  - p_data is stable throughout HOLD.
  - p_data keeps its last value after the handshake; it is not cleared.
- Bit order:
  - MSB_FIRST=1: shift left, new bit enters at bit 0; first bit ends up in p_data[WIDTH-1].
  - MSB_FIRST=0: shift right, new bit enters at bit WIDTH-1; first bit ends up in p_data[0].
- Counter: width $clog2(WIDTH+1); no wrap. It is reset to 0 on entry to IDLE.
- Throughput: at most one word per WIDTH+1 cycles (WIDTH+2 cycles with PARITY_EN), because s_ready=0 during the handshake cycle.
- abort:
  - In SHIFT or PARITY: at the edge, discard partial bits, return to IDLE, count=0. Any bit presented in that same cycle is dropped.
  - In IDLE or HOLD: ignored. A held word is never discarded by abort.
- Simultaneous events:
  - In HOLD, p_ready together with s_valid: the serial bit is not accepted, because s_ready=0.
  - clear beats abort.
  - abort beats the serial accept.

Optional Feature:
- Macro: SIPO_PARITY_EN.
- Defined:
  - PARITY state exists; one even-parity bit follows each word.
  - At the transition into HOLD, par_err <- XOR of the WIDTH data bits and the parity bit.
  - par_err is valid while p_valid=1 and is cleared to 0 on the handshake.
- Not defined:
  - No PARITY state; the port remains and par_err is tied to 0.

Decomposition:
- Shared package / include sipo_pkg:
  - state encodings: IDLE=2'd0, SHIFT=2'd1, PARITY=2'd2, HOLD=2'd3;
  - default WIDTH constant;
  - parity-mode localparam.
- One natural sub-module, sipo_bit_cnt: the bit counter.
  - Inputs: clk, clear, inc, rst_cnt.
  - Output: done, asserted when count equals WIDTH-1 and inc is high.

Test Plan:
- Reset: clear=1 for 2 cycles with s_valid=1 and s_in=1 -> p_data=0, p_valid=0, s_ready=0. First cycle after clear is released: s_ready=1.
- Back-to-back MSB-first word: WIDTH=4, MSB_FIRST=1, bits 1,0,1,1 on consecutive cycles, p_ready=0 -> p_valid=1 exactly one cycle after the 4th bit, p_data=4'b1011, s_ready=0. p_ready=1 -> p_valid=0 next cycle and IDLE.
- Gappy LSB-first word: MSB_FIRST=0, bits 1,1,0,0 with s_valid=0 for 3 idle cycles between bits -> p_data=4'b0011; count unaffected by the gaps.
- Backpressure: hold p_ready=0 for 10 cycles in HOLD while driving s_valid=1 with s_in toggling -> p_data stays 4'b1011 and no bits are accepted. The next word 0,1,1,1 then yields 4'b0111.
- Abort: abort after 2 bits -> next 4 bits 1,0,0,1 give p_data=4'b1001. abort in HOLD -> word still delivered.
- With SIPO_PARITY_EN: data 1,1,1,1 then parity 0 -> par_err=0. Data 0,0,0,1 then parity 0 -> par_err=1. par_err returns to 0 after the handshake.
